// File: rtl/fuel_pkg.sv
// Shared types and helpers for the fuel pump scheduler.
// Optional served counters are enabled with FUEL_SCHED_STATS_EN.
package fuel_pkg;

    localparam int unsigned AMT_W      = 4;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned MAX_AMOUNT = 8;

    typedef enum logic {
        FUEL_GAS = 1'b0,
        FUEL_DSL = 1'b1
    } fuel_t;

    typedef struct packed {
        fuel_t            ftype;
        logic [AMT_W-1:0] amount;
    } car_t;

    // Gasoline pumps sit at the bottom of the index range, diesel at the top.
    function automatic logic pump_in_type(
        input logic [IDX_W-1:0] idx,
        input fuel_t            ftype,
        input logic [IDX_W-1:0] n_gas,
        input logic [IDX_W-1:0] n_dsl,
        input logic [IDX_W-1:0] n_pumps
    );
        logic [IDX_W:0] i;
        logic [IDX_W:0] g;
        logic [IDX_W:0] d;
        logic [IDX_W:0] n;
        i = {1'b0, idx};
        g = {1'b0, n_gas};
        d = {1'b0, n_dsl};
        n = {1'b0, n_pumps};
        if (ftype == FUEL_GAS) begin
            return i < g;
        end
        return ((i + d) >= n) && (i < n);
    endfunction

endpackage

// File: rtl/fuel_pump_scheduler_car_fifo.sv
// Per-fuel-type car queue with synchronous flush.
// Push while full and pop while empty are ignored.
module car_fifo
    import fuel_pkg::*;
#(
    parameter int unsigned QDEPTH = 8,
    parameter int unsigned CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_i,
    input  logic             push_i,
    input  car_t             data_i,
    input  logic             pop_i,
    output car_t             head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(QDEPTH);

    car_t             mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_MAX);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign cnt_o   = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fuel_pump_scheduler.sv
// Shared pump scheduler: per-type car queues, round-robin pump grant, countdown.
// Define FUEL_SCHED_STATS_EN to add saturating served_gas/served_dsl counters.
module fuel_pump_scheduler
    import fuel_pkg::*;
#(
    parameter int unsigned N_PUMPS = 6,
    parameter int unsigned QDEPTH  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_n_gas,
    input  logic [2:0]         cfg_n_dsl,
    input  logic               car_valid,
    input  logic               car_type,
    input  logic [AMT_W-1:0]   car_amount,
    output logic               car_ready,
    output logic               car_err,
    output logic               cfg_err,
    output logic [N_PUMPS-1:0] pump_busy,
    output logic [3:0]         q_cnt_gas,
    output logic [3:0]         q_cnt_dsl,
    output logic [1:0]         disp_valid,
    output logic [2:0]         disp_pump_gas,
`ifdef FUEL_SCHED_STATS_EN
    output logic [2:0]         disp_pump_dsl,
    output logic [7:0]         served_gas,
    output logic [7:0]         served_dsl
`else
    output logic [2:0]         disp_pump_dsl
`endif
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam logic [IDX_W-1:0] NP   = IDX_W'(N_PUMPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PUMPS - 1);

    logic             cfgd_q, cfgd_d;
    logic [IDX_W-1:0] n_gas_q, n_gas_d;
    logic [IDX_W-1:0] n_dsl_q, n_dsl_d;
    logic [AMT_W-1:0] rem_q [N_PUMPS];
    logic [AMT_W-1:0] rem_d [N_PUMPS];
    logic [IDX_W-1:0] start_q [2];
    logic [IDX_W-1:0] start_d [2];
    logic [IDX_W-1:0] dp_q [2];
    logic [IDX_W-1:0] dp_d [2];
    logic [1:0]       dv_q, dv_d;
    logic             car_err_q, car_err_d;
    logic             cfg_err_q, cfg_err_d;

    car_t             head [2];
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       empty;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       disp;
    logic [IDX_W:0]   pick_r [2];

    logic [IDX_W:0]   cfg_sum;
    logic             cfg_ok;
    logic             has_pumps;
    logic             amt_ok;
    logic             car_take;
    logic             accept;
    car_t             car_in;

    // Circular search for the first idle pump of a type, starting at `start`.
    function automatic logic [IDX_W:0] pick(
        input logic [IDX_W-1:0]   start,
        input fuel_t              ftype,
        input logic [N_PUMPS-1:0] bsy,
        input logic [IDX_W-1:0]   ng,
        input logic [IDX_W-1:0]   nd
    );
        logic [IDX_W:0] res;
        int             p;
        res = '0;
        for (int k = int'(N_PUMPS) - 1; k >= 0; k--) begin
            p = int'(start) + k;
            if (p >= int'(N_PUMPS)) begin
                p = p - int'(N_PUMPS);
            end
            if (!bsy[p] && pump_in_type(IDX_W'(p), ftype, ng, nd, NP)) begin
                res = {1'b1, IDX_W'(p)};
            end
        end
        return res;
    endfunction

    for (genvar p = 0; p < N_PUMPS; p++) begin : g_busy
        assign pump_busy[p] = (rem_q[p] != '0);
    end

    assign cfg_sum   = {1'b0, cfg_n_gas} + {1'b0, cfg_n_dsl};
    assign cfg_ok    = cfg_we && (cfg_sum != '0) && (cfg_sum <= {1'b0, NP});
    assign has_pumps = car_type ? (n_dsl_q != '0) : (n_gas_q != '0);
    assign amt_ok    = (car_amount != '0)
                    && (car_amount <= AMT_W'(MAX_AMOUNT));
    assign car_ready = cfgd_q && !full[car_type] && !cfg_we;
    assign car_take  = car_valid && car_ready;
    assign accept    = car_take && amt_ok && has_pumps;
    assign push      = accept ? (car_type ? 2'b10 : 2'b01) : 2'b00;
    assign car_in    = '{ftype: fuel_t'(car_type), amount: car_amount};

    always_comb begin
        pick_r[0] = pick(start_q[0], FUEL_GAS, pump_busy, n_gas_q, n_dsl_q);
        pick_r[1] = pick(start_q[1], FUEL_DSL, pump_busy, n_gas_q, n_dsl_q);
        disp[0]   = !cfg_we && !empty[0] && pick_r[0][IDX_W];
        disp[1]   = !cfg_we && !empty[1] && pick_r[1][IDX_W];
    end

    car_fifo #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo_gas (
        .CLK     (CLK),
        .RST     (RST),
        .flush_i (cfg_ok),
        .push_i  (push[0]),
        .data_i  (car_in),
        .pop_i   (disp[0]),
        .head_o  (head[0]),
        .empty_o (empty[0]),
        .full_o  (full[0]),
        .cnt_o   (cnt[0])
    );

    car_fifo #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo_dsl (
        .CLK     (CLK),
        .RST     (RST),
        .flush_i (cfg_ok),
        .push_i  (push[1]),
        .data_i  (car_in),
        .pop_i   (disp[1]),
        .head_o  (head[1]),
        .empty_o (empty[1]),
        .full_o  (full[1]),
        .cnt_o   (cnt[1])
    );

    always_comb begin
        cfgd_d    = cfgd_q;
        n_gas_d   = n_gas_q;
        n_dsl_d   = n_dsl_q;
        rem_d     = rem_q;
        start_d   = start_q;
        dp_d      = dp_q;
        dv_d      = '0;
        car_err_d = 1'b0;
        cfg_err_d = 1'b0;
        if (cfg_we) begin
            if (cfg_ok) begin
                cfgd_d  = 1'b1;
                n_gas_d = cfg_n_gas;
                n_dsl_d = cfg_n_dsl;
                start_d = '{default: '0};
                for (int p = 0; p < int'(N_PUMPS); p++) begin
                    rem_d[p] = '0;
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            car_err_d = car_take && !(amt_ok && has_pumps);
            for (int p = 0; p < int'(N_PUMPS); p++) begin
                if (pump_busy[p]) begin
                    rem_d[p] = rem_q[p] - 1'b1;
                end
            end
            // A fresh grant overrides the countdown of its (idle) pump.
            for (int t = 0; t < 2; t++) begin
                if (disp[t]) begin
                    rem_d[pick_r[t][IDX_W-1:0]] = head[t].amount;
                    start_d[t] = (pick_r[t][IDX_W-1:0] == LAST)
                               ? '0 : pick_r[t][IDX_W-1:0] + 1'b1;
                    dp_d[t] = pick_r[t][IDX_W-1:0];
                end
            end
            dv_d = disp;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cfgd_q    <= 1'b0;
            n_gas_q   <= '0;
            n_dsl_q   <= '0;
            start_q   <= '{default: '0};
            dp_q      <= '{default: '0};
            dv_q      <= '0;
            car_err_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int p = 0; p < int'(N_PUMPS); p++) begin
                rem_q[p] <= '0;
            end
        end else begin
            cfgd_q    <= cfgd_d;
            n_gas_q   <= n_gas_d;
            n_dsl_q   <= n_dsl_d;
            start_q   <= start_d;
            dp_q      <= dp_d;
            dv_q      <= dv_d;
            car_err_q <= car_err_d;
            cfg_err_q <= cfg_err_d;
            rem_q     <= rem_d;
        end
    end

    assign car_err       = car_err_q;
    assign cfg_err       = cfg_err_q;
    assign disp_valid    = dv_q;
    assign disp_pump_gas = dp_q[0];
    assign disp_pump_dsl = dp_q[1];
    assign q_cnt_gas     = cnt[0];
    assign q_cnt_dsl     = cnt[1];

`ifdef FUEL_SCHED_STATS_EN
    logic [7:0] served_q [2];
    logic [7:0] served_d [2];

    always_comb begin
        served_d = served_q;
        for (int t = 0; t < 2; t++) begin
            if (cfg_ok) begin
                served_d[t] = '0;
            end else if (disp[t] && (served_q[t] != 8'hFF)) begin
                served_d[t] = served_q[t] + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            served_q <= '{default: '0};
        end else begin
            served_q <= served_d;
        end
    end

    assign served_gas = served_q[0];
    assign served_dsl = served_q[1];
`endif

endmodule
